// File: rtl/lspc_pkg.sv
// Shared constants for the LSPC timer control slice: 68k register bit
// positions and the active-low IPL codes driven onto the 68k.
package lspc_pkg;

  // REG_LSPCMODE bit positions
  localparam int unsigned LSPCMODE_IRQ_EN = 4;
  localparam int unsigned LSPCMODE_MODE0  = 5;
  localparam int unsigned LSPCMODE_MODE1  = 6;
  localparam int unsigned LSPCMODE_MODE2  = 7;

  // REG_IRQACK bit positions
  localparam int unsigned IRQACK_ACK_L3 = 0;
  localparam int unsigned IRQACK_ACK_L2 = 1;
  localparam int unsigned IRQACK_ACK_L1 = 2;

  // Active-low IPL codes (~level)
  typedef enum logic [2:0] {
    NIPL_NONE = 3'b111,
    NIPL_L1   = 3'b110,
    NIPL_L2   = 3'b101,
    NIPL_L3   = 3'b100
  } nipl_e;

  // Highest pending level wins; nothing pending releases the IPL lines.
  function automatic nipl_e ipl_encode(input logic p3, input logic p2, input logic p1);
    if (p3)      return NIPL_L3;
    else if (p2) return NIPL_L2;
    else if (p1) return NIPL_L1;
    else         return NIPL_NONE;
  endfunction

endpackage

// File: rtl/lspc_irq_prio.sv
// LSPC interrupt pending flags (vblank, timer, cold boot) with 68k
// acknowledge and a registered active-low IPL encoder.
module lspc_irq_prio
  import lspc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_l1,
  input  logic       set_l2,
  input  logic       ack,
  input  logic [2:0] ack_data,
  output logic [2:0] nipl
);

  logic  p1;
  logic  p2;
  logic  p3;
  logic  clr_l1;
  logic  clr_l2;
  logic  clr_l3;
  nipl_e nipl_q;

  // Decode acknowledge bits into per-level clears
  always_comb begin
    clr_l1 = ack & ack_data[IRQACK_ACK_L1];
    clr_l2 = ack & ack_data[IRQACK_ACK_L2];
    clr_l3 = ack & ack_data[IRQACK_ACK_L3];
  end

  // Pending flags: a set in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
      p3 <= 1'b1;
    end else begin
      p1 <= set_l1 | (p1 & ~clr_l1);
      p2 <= set_l2 | (p2 & ~clr_l2);
      p3 <= p3 & ~clr_l3;
    end
  end

  // Registered IPL encoder, one cycle behind the pending flags
  always_ff @(posedge clk) begin
    if (rst) nipl_q <= NIPL_NONE;
    else     nipl_q <= ipl_encode(p3, p2, p1);
  end

  assign nipl = nipl_q;

endmodule

// File: rtl/lspc_timer_ctrl.sv
// LSPC raster timer control: 68k-visible timer configuration, reload strobe
// generation for the three reload modes, PAL stop-zone count gating, and the
// interrupt priority block driving the 68k IPL pins.
module lspc_timer_ctrl
  import lspc_pkg::*;
#(
  parameter int unsigned STOP_LINES = 16
) (
  input  logic        LSPC_6M,
  input  logic        RESETP,
  input  logic [15:0] M68K_DATA,
  input  logic        WR_LSPCMODE,
  input  logic        WR_TIMER_LOW,
  input  logic        WR_TIMER_STOP,
  input  logic        WR_IRQ_ACK,
  input  logic        VBLANK_START,
  input  logic        TIMER_CO,
  input  logic [8:0]  RASTERC,
  input  logic        VMODE,
  output logic        RELOAD,
  output logic        TIMER_EN,
  output logic [2:0]  TIMER_MODE,
  output logic        TIMER_IRQ_EN,
  output logic [2:0]  nIPL
);

  logic       stop;
  logic [1:0] low_pipe;
  logic       vbl_q;
  logic       stop_zone;
  logic       unused_data;

  assign unused_data = ^{M68K_DATA[15:8], M68K_DATA[3]};

  // 68k register writes: LSPCMODE timer bits and TIMERSTOP
  always_ff @(posedge LSPC_6M) begin
    if (RESETP) begin
      TIMER_MODE   <= '0;
      TIMER_IRQ_EN <= 1'b0;
      stop         <= 1'b0;
    end else begin
      if (WR_LSPCMODE) begin
        TIMER_IRQ_EN <= M68K_DATA[LSPCMODE_IRQ_EN];
        TIMER_MODE   <= M68K_DATA[LSPCMODE_MODE2:LSPCMODE_MODE0];
      end
      if (WR_TIMER_STOP) stop <= M68K_DATA[0];
    end
  end

  // Reload event delays: 2-stage pipe for low-word writes, 1 stage for vblank
  always_ff @(posedge LSPC_6M) begin
    if (RESETP) begin
      low_pipe <= '0;
      vbl_q    <= 1'b0;
    end else begin
      low_pipe <= {low_pipe[0], WR_TIMER_LOW};
      vbl_q    <= VBLANK_START;
    end
  end

  // Reload strobe: mode bits sampled at emission; terminal count reloads combinationally
  always_comb begin
    RELOAD = (low_pipe[1] & TIMER_MODE[0])
           | (vbl_q       & TIMER_MODE[1])
           | (TIMER_CO    & TIMER_MODE[2]);
  end

  // PAL stop zone: first STOP_LINES raster lines while stop is set
  always_comb begin
    stop_zone = stop & VMODE & (32'(RASTERC) < STOP_LINES);
  end

  // Count enable, registered one cycle after the zone condition
  always_ff @(posedge LSPC_6M) begin
    if (RESETP) TIMER_EN <= 1'b1;
    else        TIMER_EN <= ~stop_zone;
  end

  lspc_irq_prio u_irq_prio (
    .clk      (LSPC_6M),
    .rst      (RESETP),
    .set_l1   (VBLANK_START),
    .set_l2   (TIMER_CO & TIMER_IRQ_EN),
    .ack      (WR_IRQ_ACK),
    .ack_data (M68K_DATA[2:0]),
    .nipl     (nIPL)
  );

endmodule

// File: doc/lspc_timer_ctrl.md
# lspc_timer_ctrl

Control and sequencing block for the LSPC 32-bit raster timer. Holds the 68k-visible timer configuration (REG_LSPCMODE timer bits, REG_TIMERSTOP) and generates the single-cycle reload strobe for the timer counter in all three reload modes. Gates counting during the PAL stop zone, and maintains the three LSPC interrupt pending flags with acknowledge and 68k IPL encoding. Sits between the 68k register decode and the timer counter chain, and drives the 68k IPL pins.

## Interface
Parameters:
- STOP_LINES, 16, number of raster lines from line 0 during which counting is suppressed when stop is active.

Ports:
- LSPC_6M  in  1  sole clock; all logic is rising-edge.
- RESETP  in  1  synchronous, active-high reset.
- M68K_DATA  in  16  68k write data.
- WR_LSPCMODE  in  1  one-cycle write strobe, already synchronised to LSPC_6M.
- WR_TIMER_LOW  in  1  one-cycle strobe; the low timer word was written.
- WR_TIMER_STOP  in  1  one-cycle strobe.
- WR_IRQ_ACK  in  1  one-cycle strobe.
- VBLANK_START  in  1  one-cycle pulse on the first vblank line.
- TIMER_CO  in  1  terminal-count carry from the counter chain.
- RASTERC  in  9  current raster line.
- VMODE  in  1  1 = PAL.
- RELOAD  out  1  one-cycle reload strobe to the counter.
- TIMER_EN  out  1  count enable to the counter.
- TIMER_MODE  out  3  mode bits: [0] reload on low write, [1] reload at vblank, [2] reload at terminal count.
- TIMER_IRQ_EN  out  1  timer IRQ enable.
- nIPL  out  3  active-low 68k interrupt priority level.

## Operation
- **WR_LSPCMODE:** TIMER_IRQ_EN ← D[4] and TIMER_MODE ← D[7:5], effective the cycle after the strobe.
- **WR_TIMER_STOP:** stop ← D[0].
- **Mode 0 reload:** a WR_TIMER_LOW strobe enters a 2-stage shift pipe. RELOAD asserts when stage 2 is set and TIMER_MODE[0]=1. TIMER_MODE[0] is sampled at emission, not at the write.
- **Mode 1 reload:** VBLANK_START is registered once. RELOAD asserts when that register is set and TIMER_MODE[1]=1.
- **Mode 2 reload:** RELOAD = TIMER_MODE[2] & TIMER_CO, combinational. This lets the counter load in the same cycle instead of wrapping.
- **RELOAD combining:** RELOAD is the OR of the three sources. Coincident sources produce one pulse, never a double-length pulse unless the sources fall in consecutive cycles.
- **Pending flags:**
  - P1 (vblank, level 1) sets on VBLANK_START.
  - P2 (timer, level 2) sets on TIMER_CO & TIMER_IRQ_EN.
  - P3 (cold boot, level 3) is set by reset.
- **WR_IRQ_ACK:** D[0] clears P3, D[1] clears P2, D[2] clears P1.
- **Set/clear collision:** a set and a clear in the same cycle leave the flag set.
- **IPL encoding:** nIPL is registered as ~(highest pending level), or 3'b111 when no flag is pending.
- **Stop zone:**
  - The zone is active when stop=1, VMODE=1 and RASTERC < STOP_LINES.
  - TIMER_EN = registered ~zone.
  - NTSC (VMODE=0) never stops.
- **Reload vs. TIMER_EN:** RELOAD is not gated by TIMER_EN.

## Timing
- **Reset values:** TIMER_MODE=0, TIMER_IRQ_EN=0, stop=0, P1=P2=0, P3=1, RELOAD=0, nIPL=3'b111, TIMER_EN=1.
- **After reset:** nIPL=3'b100 one cycle after RESETP deasserts.
- **Mode 0 latency:** WR_TIMER_LOW at cycle n gives RELOAD at cycle n+2, high for exactly one cycle.
- **Back-to-back writes:** WR_TIMER_LOW strobes in consecutive cycles give RELOAD at n+2 and n+3.
- **Mode 1 latency:** VBLANK_START at n gives RELOAD at n+1.
- **Mode 2 latency:** RELOAD in cycle n, same cycle as TIMER_CO.
- **IRQ latency:** event at n gives pending set at n+1 and nIPL updated at n+2. Ack at n gives nIPL updated at n+2.
- **Stop latency:** RASTERC/stop change at n gives TIMER_EN at n+1.
- **Reset mid-operation:** flushes the mode 0 pipe and the vblank register; no RELOAD is emitted after reset.
- **Mode 0 mode change:** clearing TIMER_MODE[0] while a write is in flight suppresses the pending pulse.

## Structure
- **Package lspc_pkg:**
  - LSPCMODE bit indices (IRQ_EN=4, MODE0=5, MODE1=6, MODE2=7).
  - IRQACK bit indices (ACK_L3=0, ACK_L2=1, ACK_L1=2).
  - IPL level constants.
- **Sub-module lspc_irq_prio:** holds the three pending flags, set/ack logic and registered nIPL encoder. The reload pipe and stop-zone logic stay in the top.

## Test plan
- **Reset:** RESETP high 3 cycles, then low → nIPL=111 during reset, 100 one cycle after release. Ack D=0x0001 → nIPL=111 two cycles later.
- **Mode 0:** write LSPCMODE=0x0020, WR_TIMER_LOW at cycle 10 → RELOAD high only at cycle 12. With MODE=0x0000 → no RELOAD.
- **Mode 2 with IRQ:** LSPCMODE=0x0090, TIMER_CO at cycle 20 → RELOAD at 20, nIPL=101 at 22. Ack D=0x0002 at 30 → nIPL=111 at 32.
- **Priority and collision:** VBLANK_START and TIMER_CO (IRQ enabled) in the same cycle → nIPL=101. Ack P2 in the same cycle as a new TIMER_CO → P2 stays set.
- **Stop zone:** stop=1, VMODE=1, RASTERC sweeps 0..20 → TIMER_EN=0 for lines 0..15, 1 from line 16 (one cycle late). VMODE=0 → TIMER_EN stays 1.
- **Coincident reloads:** MODE=0xE0, with WR_TIMER_LOW at n-2, VBLANK_START at n-1 and TIMER_CO at n → single one-cycle RELOAD at n.
